uart_tx_block: RTL and testbench

Serial transmitter for the team's 8N1 UART link. It accepts a parallel byte through a one-entry holding buffer with a ready/load handshake and shifts it out LSB-first on serial_out. Each frame is one start bit, 8 data bits and one stop bit, with CLKS_PER_BIT clocks per bit. It sits opposite the UART receiver and drives the line that the receiver samples.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_timer.sv | 47 ++++
 rtl/uart_tx_block.sv | 133 +++++++++++++
 tb/tb_uart_tx_block.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: constants and state type shared by the UART transmit and receive paths.
package uart_pkg;

  localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 10;
  localparam int unsigned UART_DATA_BITS            = 8;
  localparam logic        UART_IDLE_LEVEL           = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_tx_timer.sv
// uart_tx_timer: bit-period counter for the UART transmitter.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   enable            count while high; counter held at 0 while low
//   restart           force the counter back to 0 at this edge
//   bit_strobe        high during the last clock of a bit period (count == CLKS_PER_BIT-1)
//   bit_strobe_early  high one clock before bit_strobe (count == CLKS_PER_BIT-2)
module uart_tx_timer #(
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic restart,
  output logic bit_strobe,
  output logic bit_strobe_early
);

  localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  // Wrap at LAST; idle or restart pins the count to 0.
  always_comb begin
    count_next = '0;
    if (enable && !restart && (count != LAST)) begin
      count_next = count + CW'(1);
    end
  end

  // Strobes are registered from the next count so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count            <= '0;
      bit_strobe       <= 1'b0;
      bit_strobe_early <= 1'b0;
    end else begin
      count            <= count_next;
      bit_strobe       <= (count_next == LAST);
      bit_strobe_early <= (count_next == PRE);
    end
  end

endmodule

// File: rtl/uart_tx_block.sv
// uart_tx_block: 8N1 UART transmitter with a one-entry holding buffer.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   tx_data      byte captured when a load is accepted
//   load         write request into the holding buffer
//   tx_ready     holding buffer empty, a load is accepted this cycle
//   tx_busy      a frame is on the line
//   tx_done      pulse on the last cycle of each stop bit
//   tx_overrun   pulse the cycle after a load arrives while tx_ready=0
//   serial_out   serial line, idle high
module uart_tx_block
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int unsigned DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 load,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx_overrun,
  output logic                 serial_out
);

  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  tx_state_t            state;
  logic [DATA_BITS-1:0] buf_data;
  logic                 buf_valid;
  logic [DATA_BITS-1:0] shift;
  logic [BW-1:0]        bit_cnt;

  logic bit_strobe;
  logic bit_strobe_early;
  logic accept_c;
  logic reload_c;
  logic buf_valid_next_c;

  // Buffer drains into the shifter from IDLE, or at the end of STOP for gapless streaming.
  always_comb begin
    accept_c         = load && tx_ready;
    reload_c         = buf_valid && ((state == IDLE) || ((state == STOP) && bit_strobe));
    buf_valid_next_c = buf_valid;
    if (reload_c) buf_valid_next_c = 1'b0;
    if (accept_c) buf_valid_next_c = 1'b1;
  end

  uart_tx_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk             (clk),
    .rst             (rst),
    .enable          (state != IDLE),
    .restart         (reload_c),
    .bit_strobe      (bit_strobe),
    .bit_strobe_early(bit_strobe_early)
  );

  // Frame FSM, holding buffer and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      buf_data   <= '0;
      buf_valid  <= 1'b0;
      shift      <= '0;
      bit_cnt    <= '0;
      serial_out <= UART_IDLE_LEVEL;
      tx_ready   <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      tx_overrun <= 1'b0;
    end else begin
      buf_valid  <= buf_valid_next_c;
      tx_ready   <= !buf_valid_next_c;
      tx_overrun <= load && !tx_ready;
      // Early strobe in STOP means the next cycle is the final stop-bit cycle.
      tx_done    <= (state == STOP) && bit_strobe_early;
      if (accept_c) buf_data <= tx_data;

      case (state)
        IDLE: begin
          if (buf_valid) begin
            shift      <= buf_data;
            state      <= START;
            serial_out <= 1'b0;
            tx_busy    <= 1'b1;
          end
        end
        START: begin
          if (bit_strobe) begin
            state      <= DATA;
            bit_cnt    <= '0;
            serial_out <= shift[0];
          end
        end
        DATA: begin
          if (bit_strobe) begin
            if (bit_cnt == LAST_BIT) begin
              state      <= STOP;
              serial_out <= UART_IDLE_LEVEL;
            end else begin
              shift      <= {1'b0, shift[DATA_BITS-1:1]};
              serial_out <= shift[1];
              bit_cnt    <= bit_cnt + BW'(1);
            end
          end
        end
        STOP: begin
          if (bit_strobe) begin
            if (buf_valid) begin
              shift      <= buf_data;
              state      <= START;
              serial_out <= 1'b0;
            end else begin
              state      <= IDLE;
              tx_busy    <= 1'b0;
            end
          end
        end
        default: begin
          state      <= IDLE;
          serial_out <= UART_IDLE_LEVEL;
          tx_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_block.sv
// tb_uart_tx_block: self-checking bench for uart_tx_block with a line-decoding receiver model.
module tb_uart_tx_block;

  localparam int CPB   = 10;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       load = 1'b0;
  logic       tx_ready, tx_busy, tx_done, tx_overrun, serial_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Receiver model state
  logic [7:0] rx_q[$];
  int         framing_errs = 0;
  logic       mon_active = 1'b0;
  int         mon_t = 0;
  int         mon_bit = 0;
  logic [7:0] mon_byte = 8'h00;

  uart_tx_block #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_data   (tx_data),
    .load      (load),
    .tx_ready  (tx_ready),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .tx_overrun(tx_overrun),
    .serial_out(serial_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Mid-bit sampling receiver: start-bit detect, 8 data bits LSB first, stop bit check.
  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (serial_out === 1'b0) begin
        mon_active = 1'b1;
        mon_t = 0;
      end
    end else begin
      mon_t++;
      if ((mon_t % CPB) == (CPB / 2)) begin
        mon_bit = mon_t / CPB;
        if (mon_bit == 0) begin
          if (serial_out !== 1'b0) mon_active = 1'b0;
        end else if (mon_bit <= 8) begin
          mon_byte[mon_bit-1] = serial_out;
        end else begin
          if (serial_out !== 1'b1) framing_errs++;
          rx_q.push_back(mon_byte);
          mon_active = 1'b0;
        end
      end
    end
  end

  // Expected line level at cycle offset off (0-based) within a frame carrying b.
  function automatic logic exp_line(input logic [7:0] b, input int off);
    int bi;
    bi = off / CPB;
    if (bi == 0) return 1'b0;
    if (bi <= 8) return b[bi-1];
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b1; tx_data = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (serial_out !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 ||
          tx_done !== 1'b0 || tx_overrun !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs cyc %0d: so=%b rdy=%b busy=%b done=%b ovr=%b, required 1 1 0 0 0",
                 i, serial_out, tx_ready, tx_busy, tx_done, tx_overrun);
      end
    end
    rst = 1'b0; load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (serial_out !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b1 || tx_done !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset cyc %0d: so=%b busy=%b rdy=%b done=%b, required 1 0 1 0",
                 i, serial_out, tx_busy, tx_ready, tx_done);
      end
    end
  endtask

  task automatic test_single_byte(input logic [7:0] b);
    logic exp_so;
    rx_q.delete(); framing_errs = 0;
    load = 1'b1; tx_data = b;
    tick();
    load = 1'b0; tx_data = 8'($urandom);
    checks++;
    if (tx_ready !== 1'b0 || serial_out !== 1'b1) begin
      errors++;
      $display("FAIL single_accept: rdy=%b so=%b, required 0 1", tx_ready, serial_out);
    end
    for (int k = 1; k <= 101; k++) begin
      tick();
      exp_so = (k <= FRAME) ? exp_line(b, k - 1) : 1'b1;
      checks++;
      if (serial_out !== exp_so || tx_done !== 1'(k == FRAME) || tx_busy !== 1'(k <= FRAME)) begin
        errors++;
        $display("FAIL single_frame byte %02h cyc E+%0d: so=%b done=%b busy=%b, required %b %b %b",
                 b, k, serial_out, tx_done, tx_busy, exp_so, k == FRAME, k <= FRAME);
      end
    end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== b || framing_errs != 0) begin
      errors++;
      $display("FAIL single_rx: count=%0d first=%02h ferr=%0d, required 1 %02h 0",
               rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx, framing_errs, b);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b0, b1;
    logic exp_so;
    int dones;
    b0 = 8'h00; b1 = 8'hFF; dones = 0;
    rx_q.delete(); framing_errs = 0;
    load = 1'b1; tx_data = b0;
    tick();
    load = 1'b0;
    for (int k = 1; k <= 205; k++) begin
      tick();
      load = 1'b0;
      if (k <= FRAME)          exp_so = exp_line(b0, k - 1);
      else if (k <= 2 * FRAME) exp_so = exp_line(b1, k - FRAME - 1);
      else                     exp_so = 1'b1;
      if (tx_done === 1'b1) dones++;
      checks++;
      if (serial_out !== exp_so || tx_busy !== 1'(k <= 2 * FRAME)) begin
        errors++;
        $display("FAIL b2b_line cyc E+%0d: so=%b busy=%b, required %b %b",
                 k, serial_out, tx_busy, exp_so, k <= 2 * FRAME);
      end
      if (k == 20) begin
        load = 1'b1; tx_data = b1;
      end
    end
    checks++;
    if (dones != 2) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d, required 2", dones);
    end
    checks++;
    if (rx_q.size() != 2 || rx_q[0] !== b0 || rx_q[1] !== b1 || framing_errs != 0) begin
      errors++;
      $display("FAIL b2b_rx: count=%0d ferr=%0d, required 2 bytes %02h %02h and 0 ferr",
               rx_q.size(), framing_errs, b0, b1);
    end
  endtask

  task automatic test_overrun();
    int ovr;
    int n;
    ovr = 0; n = 0;
    rx_q.delete(); framing_errs = 0;
    load = 1'b1; tx_data = 8'h11;
    tick();
    load = 1'b0;
    tick();
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL ovr_ready_after_drain: got %b, required 1", tx_ready);
    end
    load = 1'b1; tx_data = 8'h22;
    tick();
    checks++;
    if (tx_ready !== 1'b0 || tx_overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_second_accept: rdy=%b ovr=%b, required 0 0", tx_ready, tx_overrun);
    end
    tx_data = 8'h33;
    tick();
    load = 1'b0;
    if (tx_overrun === 1'b1) ovr++;
    checks++;
    if (tx_overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_pulse: got %b, required 1", tx_overrun);
    end
    while (tx_busy === 1'b1 && n < 4 * FRAME) begin
      tick();
      n++;
      if (tx_overrun === 1'b1) ovr++;
    end
    checks++;
    if (n >= 4 * FRAME || ovr != 1) begin
      errors++;
      $display("FAIL ovr_count: pulses=%0d waited=%0d, required 1 pulse and idle line", ovr, n);
    end
    checks++;
    if (rx_q.size() != 2 || rx_q[0] !== 8'h11 || rx_q[1] !== 8'h22 || framing_errs != 0) begin
      errors++;
      $display("FAIL ovr_rx: count=%0d ferr=%0d, required 2 bytes 11 22 and 0 ferr",
               rx_q.size(), framing_errs);
    end
  endtask

  task automatic test_reload_collision();
    logic [7:0] a, b, c;
    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
    rx_q.delete(); framing_errs = 0;
    load = 1'b1; tx_data = a;
    tick();
    load = 1'b0;
    for (int k = 1; k <= 205; k++) begin
      tick();
      load = 1'b0;
      if (k == FRAME + 1) begin
        checks++;
        if (tx_overrun !== 1'b1 || tx_ready !== 1'b1 || serial_out !== 1'b0) begin
          errors++;
          $display("FAIL collision_edge: ovr=%b rdy=%b so=%b, required 1 1 0",
                   tx_overrun, tx_ready, serial_out);
        end
      end
      if (k == 1) begin
        load = 1'b1; tx_data = b;
      end
      if (k == FRAME) begin
        checks++;
        if (tx_ready !== 1'b0 || tx_done !== 1'b1) begin
          errors++;
          $display("FAIL collision_pre: rdy=%b done=%b, required 0 1", tx_ready, tx_done);
        end
        load = 1'b1; tx_data = c;
      end
    end
    checks++;
    if (rx_q.size() != 2 || rx_q[0] !== a || rx_q[1] !== b || framing_errs != 0) begin
      errors++;
      $display("FAIL collision_rx: count=%0d ferr=%0d, required 2 bytes %02h %02h",
               rx_q.size(), framing_errs, a, b);
    end
  endtask

  task automatic test_reset_mid_frame();
    int dones;
    dones = 0;
    rx_q.delete(); framing_errs = 0;
    load = 1'b1; tx_data = 8'h3C;
    tick();
    load = 1'b0;
    for (int k = 1; k <= 55; k++) begin
      tick();
      load = 1'b0;
      if (k == 30) begin
        load = 1'b1; tx_data = 8'h99;
      end
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (serial_out !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_async: so=%b busy=%b rdy=%b, required 1 0 1",
               serial_out, tx_busy, tx_ready);
    end
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (tx_done === 1'b1) dones++;
      checks++;
      if (serial_out !== 1'b1 || tx_busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_discard cyc %0d: so=%b busy=%b, required 1 0", k, serial_out, tx_busy);
      end
    end
    checks++;
    if (dones != 0 || rx_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: dones=%0d rx=%0d, required 0 0", dones, rx_q.size());
    end
    test_single_byte(8'h5A);
  endtask

  task automatic test_stream();
    logic [7:0] bytes[256];
    int idx, n, dones, ovr, first_cyc, last_done;
    logic first_pending;
    idx = 0; n = 0; dones = 0; ovr = 0; first_cyc = 0; last_done = 0;
    for (int i = 0; i < 256; i++) bytes[i] = 8'($urandom);
    rx_q.delete(); framing_errs = 0;
    while ((idx < 256 || tx_busy === 1'b1) && n < 256 * FRAME + 500) begin
      first_pending = 1'b0;
      if (tx_ready === 1'b1 && idx < 256) begin
        load = 1'b1; tx_data = bytes[idx];
        first_pending = (idx == 0);
        idx++;
      end else begin
        load = 1'b0;
      end
      tick();
      n++;
      if (first_pending) first_cyc = cyc;
      if (tx_done === 1'b1) begin
        dones++;
        last_done = cyc;
      end
      if (tx_overrun === 1'b1) ovr++;
    end
    load = 1'b0;
    checks++;
    if (n >= 256 * FRAME + 500) begin
      errors++;
      $display("FAIL stream_timeout: loaded=%0d busy=%b", idx, tx_busy);
    end
    checks++;
    if (dones != 256 || ovr != 0 || framing_errs != 0) begin
      errors++;
      $display("FAIL stream_counts: dones=%0d ovr=%0d ferr=%0d, required 256 0 0", dones, ovr, framing_errs);
    end
    checks++;
    if (last_done - first_cyc != 256 * FRAME) begin
      errors++;
      $display("FAIL stream_rate: span=%0d, required %0d", last_done - first_cyc, 256 * FRAME);
    end
    checks++;
    if (rx_q.size() != 256) begin
      errors++;
      $display("FAIL stream_rx_count: got %0d, required 256", rx_q.size());
    end else begin
      for (int i = 0; i < 256; i++) begin
        checks++;
        if (rx_q[i] !== bytes[i]) begin
          errors++;
          $display("FAIL stream_byte %0d: got %02h, required %02h", i, rx_q[i], bytes[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte(8'hA5);
    test_single_byte(8'($urandom));
    test_back_to_back();
    test_overrun();
    test_reload_collision();
    test_reset_mid_frame();
    test_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
